e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Execute-stage multiply/divide unit; consumes operands of the instruction held in the D/E pipeline register.
//  Performs multi-cycle mult/multu/div/divu, single-cycle mthi/mtlo, and holds the architectural HI/LO.
//  Exports busy so the hazard unit can stall later MDU instructions.
//  The flush request suppresses starts from instructions that exception handling cancels.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd family when enabled); >=1
//  DIV_CYCLES   10  busy cycles for div/divu; >=1
// PORTS
//  clk     in   1   clock; all state updates on rising edge
//  reset   in   1   synchronous, active-high reset
//  start   in   1   qualifies mdu_op this cycle; no op is acted on without start=1
//  mdu_op  in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd,8 maddu,9 msub
//  a       in   32  rs operand (forwarded value)
//  b       in   32  rt operand (forwarded value)
//  req     in   1   exception/interrupt flush from CP0; blocks a start in the same cycle
//  busy    out  1   registered; high while a multi-cycle op is in flight
//  hi      out  32  architectural HI
//  lo      out  32  architectural LO
// BEHAVIOUR
//  Reset: state IDLE, counter 0, latched operands 0, busy=0, hi=0, lo=0; overrides everything, including mid-op.
//  Accept: start & ~req & ~busy. A start while busy=1 or req=1 is dropped with no state change.
//    The hazard unit must stall in those cases.
//  mthi/mtlo accepted at edge t: hi (or lo) <= a at edge t; busy stays 0.
//  mult/multu/div/divu accepted at edge t:
//    - Latch a, b, op; state IDLE->RUN; counter <= N-1 (N = MULT_CYCLES or DIV_CYCLES).
//    - busy=1 for exactly N cycles (after edges t..t+N-1).
//    - At edge t+N: hi/lo <= result; busy <= 0; state RUN->IDLE.
//    - Back-to-back: a new start is accepted in the cycle after busy falls.
//  Counter: decrement each RUN cycle; the RUN->IDLE transition occurs at the edge where counter==0.
//  mult: {hi,lo} = $signed(a)*$signed(b), 64-bit. multu: unsigned 64-bit product.
//  div:
//    - lo = signed quotient, truncated toward zero; hi = remainder, taking the sign of the dividend.
//    - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
//  divu: lo = a/b, hi = a%b, unsigned.
//  Divide by zero (b=0): full DIV_CYCLES busy; hi/lo left unchanged at completion.
//  req while RUN: the in-flight op is not cancelled and completes normally (it was issued before the flush).
//  HI/LO reads are combinational from registers; no bypass of a pending result.
//  Ops 0 and 10-15 with start=1 are no-ops; busy stays 0.
// CONFIGURATION
//  MDU_MADD_EN defined:
//    - Ops 7/8/9 are valid, use MULT_CYCLES latency, and read {hi,lo} at completion (not at start).
//    - madd: {hi,lo} += signed a*b. maddu: {hi,lo} += unsigned a*b. msub: {hi,lo} -= signed a*b.
//    - All arithmetic is 64-bit modulo 2^64.
//  MDU_MADD_EN undefined: ops 7/8/9 are no-ops exactly like op 0; no accumulate datapath is synthesised.
// TESTING
//  T1 mult a=0xFFFFFFFF b=2 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE, busy=0.
//  T2 multu a=0xFFFFFFFF b=2 -> after 5 busy cycles hi=0x00000001 lo=0xFFFFFFFE.
//  T3 div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF;
//     a 2nd start during busy -> ignored, result unchanged.
//  T4 mthi a=0x1234 -> hi=0x1234 next cycle, busy=0.
//     Then divu a=5 b=0 -> busy 10 cycles, hi=0x1234 and lo unchanged.
//  T5 start mult with req=1 -> busy stays 0, hi/lo unchanged.
//     req asserted on cycle 2 of a running div -> div completes with the correct result.
//  T6 reset at cycle 4 of a div -> next cycle busy=0 hi=0 lo=0.
//     With MDU_MADD_EN: hi=0 lo=10, madd a=3 b=4 -> lo=22; msub a=1 b=30 -> hi=0xFFFFFFFF lo=0xFFFFFFF8.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
//   Runs multi-cycle mult/multu/div/divu on latched operands, executes
//   mthi/mtlo in a single cycle, and holds the architectural HI/LO pair.
//   busy is registered and covers the whole multi-cycle window, so the hazard
//   unit can stall younger MDU instructions. A flush (req) blocks a start in
//   the same cycle, but an operation already in flight still completes.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub (ops 7/8/9),
//   which accumulate into {hi,lo} at completion. Without it those ops are no-ops.
// Ports:
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous active-high reset
//   start   in   1   qualifies mdu_op
//   mdu_op  in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 madd,8 maddu,9 msub
//   a, b    in   32  rs / rt operands
//   req     in   1   flush request, blocks a start this cycle
//   busy    out  1   multi-cycle op in flight
//   hi, lo  out  32  architectural HI / LO
//
// state | meaning
// IDLE  | ready to accept a start
// RUN   | multi-cycle op in flight, counter counts down to 0
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          is_mul, is_div;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   abs_a, abs_b, quo_u, rem_u, quo_s, rem_s;

  assign accept = start & ~req & ~busy_q;

  always_comb begin
    is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (mdu_op == OP_MADD) || (mdu_op == OP_MADDU) || (mdu_op == OP_MSUB);
`endif
    is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  end

  // Full-width operands so the 64-bit products are exact modulo 2^64.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes; avoids the overflow case of min/-1, where
  // the magnitude 0x80000000 divided by 1 wraps back to 0x80000000.
  assign abs_a = a_q[31] ? (32'd0 - a_q) : a_q;
  assign abs_b = b_q[31] ? (32'd0 - b_q) : b_q;
  assign quo_u = abs_a / abs_b;
  assign rem_u = abs_a % abs_b;
  assign quo_s = (a_q[31] ^ b_q[31]) ? (32'd0 - quo_u) : quo_u;
  assign rem_s = a_q[31] ? (32'd0 - rem_u) : rem_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mdu_op == OP_MTHI) hi_d = a;
          if (mdu_op == OP_MTLO) lo_d = a;
          if (is_mul || is_div) begin
            a_d     = a;
            b_d     = b;
            op_d    = mdu_op;
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
          end
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != 32'd0) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = a_q / b_q;
                hi_d = a_q % b_q;
              end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed-vector bench for e_mdu with hand-computed expected values.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .a      (a),
    .b      (b),
    .req    (req),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inject: 0 none, 1 extra mult start at busy cycle 2, 2 req pulse at busy cycle 2
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic rq, input int inject, output int nc);
    start  = 1'b1;
    mdu_op = op;
    a      = av;
    b      = bv;
    req    = rq;
    @(posedge clk); #1;
    start = 1'b0;
    req   = 1'b0;
    nc    = 0;
    while (busy === 1'b1 && nc < 200) begin
      nc++;
      start = 1'b0;
      req   = 1'b0;
      if (nc == 2 && inject == 1) begin
        start  = 1'b1;
        mdu_op = 4'd1;
        a      = 32'd3;
        b      = 32'd3;
      end
      if (nc == 2 && inject == 2) req = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    req   = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 4'd0;
    a      = 32'd0;
    b      = 32'd0;
    req    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, ncyc);
    check("mult_cycles", 64'(ncyc), 64'd5);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, ncyc);
    check("multu_cycles", 64'(ncyc), 64'd5);
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1, ncyc);
    check("div_busy_start_cycles", 64'(ncyc), 64'd10);
    check("div_busy_start_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    @(posedge clk); #1;
    check("dropped_start_no_run", 64'(busy), 64'd0);

    run_op(4'd5, 32'h0000_1234, 32'd0, 1'b0, 0, ncyc);
    check("mthi_cycles", 64'(ncyc), 64'd0);
    check("mthi_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFD);

    run_op(4'd4, 32'd5, 32'd0, 1'b0, 0, ncyc);
    check("divu0_cycles", 64'(ncyc), 64'd10);
    check("divu0_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFD);

    run_op(4'd1, 32'd7, 32'd9, 1'b1, 0, ncyc);
    check("req_start_cycles", 64'(ncyc), 64'd0);
    check("req_start_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFD);

    run_op(4'd3, 32'd100, 32'hFFFF_FFF9, 1'b0, 2, ncyc);
    check("div_req_cycles", 64'(ncyc), 64'd10);
    check("div_req_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFF2);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, ncyc);
    check("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, ncyc);
    check("div_pos_neg_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    run_op(4'd4, 32'hFFFF_FFFF, 32'd16, 1'b0, 0, ncyc);
    check("divu_hilo", {hi, lo}, 64'h0000_000F_0FFF_FFFF);

    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, ncyc);
    check("mult_min_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

    run_op(4'd6, 32'h0000_ABCD, 32'd0, 1'b0, 0, ncyc);
    check("mtlo_cycles", 64'(ncyc), 64'd0);
    check("mtlo_hilo", {hi, lo}, 64'h4000_0000_0000_ABCD);

    run_op(4'd0, 32'd1, 32'd1, 1'b0, 0, ncyc);
    check("op0_cycles", 64'(ncyc), 64'd0);
    run_op(4'd12, 32'd1, 32'd1, 1'b0, 0, ncyc);
    check("op12_cycles", 64'(ncyc), 64'd0);
    check("noop_hilo", {hi, lo}, 64'h4000_0000_0000_ABCD);

`ifndef MDU_MADD_EN
    run_op(4'd7, 32'd3, 32'd4, 1'b0, 0, ncyc);
    check("op7_noop_cycles", 64'(ncyc), 64'd0);
    check("op7_noop_hilo", {hi, lo}, 64'h4000_0000_0000_ABCD);
`endif

    // Reset in the middle of a divide.
    start  = 1'b1;
    mdu_op = 4'd3;
    a      = 32'd50;
    b      = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_hilo", {hi, lo}, 64'd0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("after_reset_idle_hilo", {hi, lo}, 64'd0);

`ifdef MDU_MADD_EN
    run_op(4'd6, 32'd10, 32'd0, 1'b0, 0, ncyc);
    run_op(4'd7, 32'd3, 32'd4, 1'b0, 0, ncyc);
    check("madd_cycles", 64'(ncyc), 64'd5);
    check("madd_hilo", {hi, lo}, 64'd22);
    run_op(4'd9, 32'd1, 32'd30, 1'b0, 0, ncyc);
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF8);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
